// File: rtl/sa_result_writer_pkg.sv
// Shared constants and FSM state encoding for the systolic-array result writer.
package sa_result_writer_pkg;

  localparam int unsigned       NUM_RES_DEF   = 9;
  localparam int unsigned       DATA_W_DEF    = 16;
  localparam int unsigned       ADDR_W_DEF    = 6;
  localparam logic [5:0]        BASE_ADDR_DEF = 6'd18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sa_result_buffer.sv
// Capture register for the PE results plus index-selected read mux.
// Optional clamp of negative entries to zero under SA_RESULT_WRITER_RELU_EN.
module sa_result_buffer
  import sa_result_writer_pkg::*;
#(
  parameter int unsigned NUM_RES = NUM_RES_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned IDX_W   = $clog2(NUM_RES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_i,
  input  logic [DATA_W-1:0] res_i [NUM_RES],
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] buf_q [NUM_RES];
  logic [DATA_W-1:0] sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q <= '{default: '0};
    end else if (cap_i) begin
      buf_q <= res_i;
    end
  end

  // On the capture edge the buffer is not yet loaded, so the first word bypasses it.
  always_comb begin
    sel = cap_i ? res_i[rd_idx_i] : buf_q[rd_idx_i];
`ifdef SA_RESULT_WRITER_RELU_EN
    rd_data_o = sel[DATA_W-1] ? '0 : sel;
`else
    rd_data_o = sel;
`endif
  end

endmodule

// File: rtl/sa_result_writer.sv
// Drains nine captured PE results into memory, one word per cycle from BASE_ADDR.
// Build option: SA_RESULT_WRITER_RELU_EN clamps negative results to zero.
module sa_result_writer
  import sa_result_writer_pkg::*;
#(
  parameter int unsigned       NUM_RES   = NUM_RES_DEF,
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] result_1,
  input  logic [DATA_W-1:0] result_2,
  input  logic [DATA_W-1:0] result_3,
  input  logic [DATA_W-1:0] result_4,
  input  logic [DATA_W-1:0] result_5,
  input  logic [DATA_W-1:0] result_6,
  input  logic [DATA_W-1:0] result_7,
  input  logic [DATA_W-1:0] result_8,
  input  logic [DATA_W-1:0] result_9,
  output logic              busy,
  output logic              wen,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] d,
  output logic              is_done_o
);

  localparam int unsigned       IDX_W    = $clog2(NUM_RES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_RES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              cap;
  logic [DATA_W-1:0] res [NUM_RES];
  logic [DATA_W-1:0] rd_data;

  logic              wen_q, wen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] d_q, d_d;

  assign res[0] = result_1;
  assign res[1] = result_2;
  assign res[2] = result_3;
  assign res[3] = result_4;
  assign res[4] = result_5;
  assign res[5] = result_6;
  assign res[6] = result_7;
  assign res[7] = result_8;
  assign res[8] = result_9;

  sa_result_buffer #(
    .NUM_RES (NUM_RES),
    .DATA_W  (DATA_W),
    .IDX_W   (IDX_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .cap_i     (cap),
    .res_i     (res),
    .rd_idx_i  (idx_d),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      d_q     <= d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = WRITE;
          idx_d   = '0;
          cap     = 1'b1;
        end
      end
      WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state and index.
  always_comb begin
    wen_d  = 1'b0;
    addr_d = '0;
    d_d    = '0;
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    if (state_d == WRITE) begin
      wen_d  = 1'b1;
      addr_d = BASE_ADDR + ADDR_W'(idx_d);
      d_d    = rd_data;
    end
  end

  assign busy      = busy_q;
  assign wen       = wen_q;
  assign addr      = addr_q;
  assign d         = d_q;
  assign is_done_o = done_q;

endmodule

// File: tb/tb_sa_result_writer.sv
// Directed + randomized bench for sa_result_writer (default base and base 60).
module tb_sa_result_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] res [9];

  logic        busy, wen, done;
  logic [5:0]  addr;
  logic [15:0] d;
  logic        busy2, wen2, done2;
  logic [5:0]  addr2;
  logic [15:0] d2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sa_result_writer dut (
    .clk(clk), .rst(rst), .en(en),
    .result_1(res[0]), .result_2(res[1]), .result_3(res[2]),
    .result_4(res[3]), .result_5(res[4]), .result_6(res[5]),
    .result_7(res[6]), .result_8(res[7]), .result_9(res[8]),
    .busy(busy), .wen(wen), .addr(addr), .d(d), .is_done_o(done)
  );

  sa_result_writer #(.BASE_ADDR(6'd60)) dut60 (
    .clk(clk), .rst(rst), .en(en),
    .result_1(res[0]), .result_2(res[1]), .result_3(res[2]),
    .result_4(res[3]), .result_5(res[4]), .result_6(res[5]),
    .result_7(res[6]), .result_8(res[7]), .result_9(res[8]),
    .busy(busy2), .wen(wen2), .addr(addr2), .d(d2), .is_done_o(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Value that memory should receive for a captured result.
  function automatic logic [15:0] model_word(input logic [15:0] v);
`ifdef SA_RESULT_WRITER_RELU_EN
    return ($signed(v) < 0) ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk_quiet(input string tag, input logic exp_busy);
    chk({tag, ".wen"},  {31'd0, wen},  32'd0);
    chk({tag, ".addr"}, {26'd0, addr}, 32'd0);
    chk({tag, ".d"},    {16'd0, d},    32'd0);
    chk({tag, ".done"}, {31'd0, done}, 32'd0);
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, exp_busy});
    chk({tag, ".wen60"}, {31'd0, wen2}, 32'd0);
  endtask

  // Called at the negedge of the first write cycle; returns at the negedge of
  // the cycle following DONE. scramble: perturb inputs/en during the drain.
  task automatic check_drain(input logic [15:0] cap [9], input bit scramble, input bit hold);
    for (int i = 0; i < 9; i++) begin
      chk("wr.wen",  {31'd0, wen},  32'd1);
      chk("wr.busy", {31'd0, busy}, 32'd1);
      chk("wr.done", {31'd0, done}, 32'd0);
      chk("wr.addr", {26'd0, addr}, (18 + i) % 64);
      chk("wr.d",    {16'd0, d},    {16'd0, model_word(cap[i])});
      chk("wr60.addr", {26'd0, addr2}, (60 + i) % 64);
      chk("wr60.d",    {16'd0, d2},    {16'd0, model_word(cap[i])});
      if (scramble) begin
        for (int k = 0; k < 9; k++) res[k] = 16'($urandom);
        en = 1'($urandom);
      end
      @(negedge clk);
    end
    chk("done.pulse", {31'd0, done}, 32'd1);
    chk("done.wen",   {31'd0, wen},  32'd0);
    chk("done.addr",  {26'd0, addr}, 32'd0);
    chk("done.d",     {16'd0, d},    32'd0);
    chk("done.busy",  {31'd0, busy}, 32'd1);
    if (!hold) en = 1'b0;
    @(negedge clk);
  endtask

  logic [15:0] vals [9];

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    for (int k = 0; k < 9; k++) res[k] = '0;
    repeat (2) @(negedge clk);
    chk_quiet("reset", 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("idle", 1'b0);

    // Ramp pattern result_k = k*0x0101.
    for (int k = 0; k < 9; k++) begin
      vals[k] = 16'((k + 1) * 16'h0101);
      res[k]  = vals[k];
    end
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check_drain(vals, 1'b0, 1'b0);
    chk_quiet("after_ramp", 1'b0);

    // Inputs and en change freely during the drain; captured data must be written.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 9; k++) begin
        vals[k] = 16'($urandom);
        res[k]  = vals[k];
      end
      en = 1'b1;
      @(negedge clk);
      check_drain(vals, 1'b1, 1'b0);
      chk_quiet("after_rand", 1'b0);
    end

    // Negative / positive pair around the clamp boundary.
    for (int k = 0; k < 9; k++) begin
      vals[k] = 16'($urandom_range(0, 16'h7fff));
      res[k]  = vals[k];
    end
    vals[2] = 16'hFFF0; res[2] = vals[2];
    vals[3] = 16'h0010; res[3] = vals[3];
    vals[8] = 16'h8000; res[8] = vals[8];
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check_drain(vals, 1'b0, 1'b0);

    // en held high: back-to-back drains separated by one idle cycle.
    for (int k = 0; k < 9; k++) begin
      vals[k] = 16'($urandom);
      res[k]  = vals[k];
    end
    en = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      check_drain(vals, 1'b0, (r != 2));
      chk_quiet("hold_gap", 1'b0);
      if (r != 2) @(negedge clk);
    end

    // Reset asserted in the 4th write cycle.
    for (int k = 0; k < 9; k++) begin
      vals[k] = 16'($urandom);
      res[k]  = vals[k];
    end
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("pre_rst.addr", {26'd0, addr}, 18 + i);
      @(negedge clk);
    end
    chk("rst_cycle.wen", {31'd0, wen}, 32'd1);
    chk("rst_cycle.addr", {26'd0, addr}, 32'd21);
    rst = 1'b0;
    #1;
    chk_quiet("async_rst", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("post_rst", 1'b0);
    for (int k = 0; k < 9; k++) begin
      vals[k] = 16'($urandom);
      res[k]  = vals[k];
    end
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check_drain(vals, 1'b0, 1'b0);
    chk_quiet("final_idle", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
